// File: rtl/ccff_loader.sv
// ccff_loader
//   Serial configuration loader for a routing/connection block config chain.
//   Takes the bitstream as DATA_W-bit words over valid/ready, shifts each word
//   LSB-first onto ccff_head while ccff_shift_en gates prog_clk to the chain.
//   With verify latched at start, each bit leaving ccff_tail is compared with
//   the bit entering ccff_head (host resends the same stream) and a sticky
//   error is raised on any difference.
// Ports
//   prog_clk, prog_rst_n       : clock, async active-low reset
//   start, verify, abort       : control (start pulse, verify with start, abort level)
//   cfg_data/cfg_valid/ready   : bitstream word handshake
//   ccff_head, ccff_shift_en   : registered drive into the chain
//   ccff_tail                  : serial data back out of the chain
//   busy, done, error          : status
module ccff_loader #(
  parameter int CHAIN_LEN = 22,
  parameter int DATA_W    = 8,
  parameter int CNT_W     = $clog2(CHAIN_LEN+1)
) (
  input  logic              prog_clk,
  input  logic              prog_rst_n,
  input  logic              start,
  input  logic              verify,
  input  logic              abort,
  input  logic [DATA_W-1:0] cfg_data,
  input  logic              cfg_valid,
  output logic              cfg_ready,
  output logic              ccff_head,
  output logic              ccff_shift_en,
  input  logic              ccff_tail,
  output logic              busy,
  output logic              done,
  output logic              error
);
  localparam int RW = $clog2(DATA_W+1);

  typedef enum logic [1:0] {S_IDLE, S_FETCH, S_SHIFT, S_DONE} state_e;

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;      // bits shifted into the chain this pass
  logic [RW-1:0]     rem_q, rem_d;      // bits of the current word still to present
  logic [DATA_W-1:0] shreg_q, shreg_d;  // bits not yet moved onto ccff_head
  logic              head_q, head_d;
  logic              shen_q, shen_d;
  logic              err_q, err_d;
  logic              vfy_q, vfy_d;
  int                left;
  int                nbits;

  always_ff @(posedge prog_clk or negedge prog_rst_n) begin
    if (!prog_rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      rem_q   <= '0;
      shreg_q <= '0;
      head_q  <= 1'b0;
      shen_q  <= 1'b0;
      err_q   <= 1'b0;
      vfy_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rem_q   <= rem_d;
      shreg_q <= shreg_d;
      head_q  <= head_d;
      shen_q  <= shen_d;
      err_q   <= err_d;
      vfy_q   <= vfy_d;
    end
  end

  always_comb begin
    // Bits this word contributes: a full word, or what is left of the chain.
    left    = CHAIN_LEN - int'(cnt_q);
    nbits   = (left < DATA_W) ? left : DATA_W;
    state_d = state_q;
    cnt_d   = cnt_q;
    rem_d   = rem_q;
    shreg_d = shreg_q;
    head_d  = head_q;
    shen_d  = shen_q;
    err_d   = err_q;
    vfy_d   = vfy_q;
    cfg_ready = 1'b0;
    if (abort) begin
      state_d = S_IDLE;
      shen_d  = 1'b0;
      head_d  = 1'b0;
    end else begin
      case (state_q)
        S_IDLE, S_DONE: begin
          if (start) begin
            state_d = S_FETCH;
            cnt_d   = '0;
            err_d   = 1'b0;
            vfy_d   = verify;
          end
        end
        S_FETCH: begin
          cfg_ready = 1'b1;
          if (cfg_valid) begin
            // Bit 0 goes straight to the head register so shifting starts
            // the cycle right after acceptance.
            head_d  = cfg_data[0];
            shreg_d = cfg_data >> 1;
            shen_d  = 1'b1;
            rem_d   = RW'(nbits - 1);
            state_d = S_SHIFT;
          end
        end
        S_SHIFT: begin
          cnt_d = cnt_q + 1'b1;
          if (vfy_q && (ccff_tail != head_q)) err_d = 1'b1;
          if (rem_q != '0) begin
            head_d  = shreg_q[0];
            shreg_d = shreg_q >> 1;
            rem_d   = rem_q - 1'b1;
          end else begin
            // Last bit of this word: any unused upper bits are dropped here.
            shen_d  = 1'b0;
            head_d  = 1'b0;
            state_d = (int'(cnt_q) + 1 < CHAIN_LEN) ? S_FETCH : S_DONE;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  assign ccff_head     = head_q;
  assign ccff_shift_en = shen_q;
  assign busy          = (state_q == S_FETCH) || (state_q == S_SHIFT);
  assign done          = (state_q == S_DONE);
  assign error         = err_q;

endmodule

// File: tb/tb_ccff_loader.sv
// Bench for ccff_loader: two instances (22-bit chain and 8-bit chain) share the
// stimulus; a bit-level chain model closes the head->tail loop. Expected values
// come from the packed bitstream (words concatenated LSB-first, cut to CHAIN_LEN)
// and the word-cost rule (1 + bits per word, plus stall cycles).
module tb_ccff_loader;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n, start, verify, abort, cfg_valid;
  logic [7:0] cfg_data;
  logic       r22, h22, s22, b22, d22, e22;
  logic       r8, h8, s8, b8, d8, e8;
  logic [21:0] ch22 = '0;
  logic [7:0]  ch8  = '0;

  ccff_loader #(.CHAIN_LEN(22), .DATA_W(8)) dut22 (
    .prog_clk(clk), .prog_rst_n(rst_n), .start(start), .verify(verify),
    .abort(abort), .cfg_data(cfg_data), .cfg_valid(cfg_valid), .cfg_ready(r22),
    .ccff_head(h22), .ccff_shift_en(s22), .ccff_tail(ch22[21]),
    .busy(b22), .done(d22), .error(e22));

  ccff_loader #(.CHAIN_LEN(8), .DATA_W(8)) dut8 (
    .prog_clk(clk), .prog_rst_n(rst_n), .start(start), .verify(verify),
    .abort(abort), .cfg_data(cfg_data), .cfg_valid(cfg_valid), .cfg_ready(r8),
    .ccff_head(h8), .ccff_shift_en(s8), .ccff_tail(ch8[7]),
    .busy(b8), .done(d8), .error(e8));

  // Chain models: the first bit entered ends up deepest (next at the tail).
  always @(posedge clk) if (s22) ch22 <= {ch22[20:0], h22};
  always @(posedge clk) if (s8)  ch8  <= {ch8[6:0], h8};

  bit sel;  // 0: observe the 22-bit instance, 1: the 8-bit one
  logic m_r, m_h, m_s, m_b, m_d, m_e;
  assign m_r = sel ? r8 : r22;
  assign m_h = sel ? h8 : h22;
  assign m_s = sel ? s8 : s22;
  assign m_b = sel ? b8 : b22;
  assign m_d = sel ? d8 : d22;
  assign m_e = sel ? e8 : e22;

  int total = 0, bad = 0;
  int L;
  int nshift, nacc, overlap, done_rel, err_rel;
  logic [31:0] hbits;
  int rdy_q[$];
  logic [7:0] w [4];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] stream_of();
    return {w[3], w[2], w[1], w[0]} & ((32'h1 << L) - 32'h1);
  endfunction

  function automatic logic [31:0] chain_val();
    logic [31:0] v = '0;
    for (int i = 0; i < L; i++) begin
      if (sel) v[i] = ch8[L-1-i];
      else     v[i] = ch22[L-1-i];
    end
    return v;
  endfunction

  function automatic int first_diff(input logic [31:0] a, input logic [31:0] b);
    int f = -1;
    for (int i = 31; i >= 0; i--) if (a[i] != b[i]) f = i;
    return f;
  endfunction

  // One pass: start, feed nw words (stall_n idle cycles before word stall_k),
  // optional stray start / abort / reset at a given cycle after the start edge.
  task automatic run_pass(input bit v, input int nw, input int stall_k, input int stall_n,
                          input int start_rel, input int abort_rel, input int rst_rel);
    int rel, k, stall_left;
    bit acc, fin;
    nshift = 0; nacc = 0; overlap = 0; done_rel = -1; err_rel = -1; hbits = '0;
    rdy_q.delete();
    @(negedge clk); start = 1'b1; verify = v; cfg_valid = 1'b0; abort = 1'b0;
    @(negedge clk); start = 1'b0; verify = 1'b0;
    rel = 0; k = 0; acc = 1'b0; fin = 1'b0;
    stall_left = (stall_k == 0) ? stall_n : 0;
    chk("cleared_at_start", {m_d, m_e}, 2'b00);
    while (!fin && rel < 300) begin
      if (acc) begin
        nacc++; k++;
        stall_left = (k == stall_k) ? stall_n : 0;
      end
      if (m_s && nshift < 32) begin hbits[nshift] = m_h; nshift++; end
      if (m_r) rdy_q.push_back(rel);
      if (m_r && m_s) overlap++;
      if (m_e && err_rel < 0) err_rel = rel;
      if (m_d) begin
        done_rel = rel; fin = 1'b1;
      end else if (rel == abort_rel) begin
        abort = 1'b1; cfg_valid = 1'b0;
        @(negedge clk); abort = 1'b0;
        chk("abort_outputs", {m_r, m_s, m_d, m_b}, 4'b0000);
        fin = 1'b1;
      end else if (rel == rst_rel) begin
        #2 rst_n = 1'b0;
        #1 chk("async_reset", {m_r, m_h, m_s, m_b, m_d, m_e}, 6'b0);
        @(negedge clk); rst_n = 1'b1; cfg_valid = 1'b0;
        fin = 1'b1;
      end else begin
        start = (rel == start_rel);
        if (k < nw && m_r && stall_left > 0) begin
          cfg_valid = 1'b0; stall_left--;
        end else begin
          cfg_valid = (k < nw);
        end
        cfg_data = w[k & 3];
        acc = cfg_valid && m_r;
        @(negedge clk); rel++;
      end
    end
    start = 1'b0; cfg_valid = 1'b0;
    chk("pass_ended", fin, 1'b1);
  endtask

  initial begin
    logic [31:0] exp, prev22, prev8;
    int fd, sk, sn;
    bit reuse;
    sel = 1'b0; L = 22;
    rst_n = 1'b0; start = 1'b0; verify = 1'b0; abort = 1'b0;
    cfg_valid = 1'b0; cfg_data = '0;
    w[0] = 8'hA5; w[1] = 8'h3C; w[2] = 8'h2F; w[3] = 8'h00;
    repeat (2) @(negedge clk);
    chk("reset22", {r22, h22, s22, b22, d22, e22}, 6'b0);
    chk("reset8",  {r8, h8, s8, b8, d8, e8}, 6'b0);
    rst_n = 1'b1;

    // Basic load, valid held high
    run_pass(1'b0, 3, -1, 0, -1, -1, -1);
    exp = stream_of();
    chk("A_nshift", nshift, 22);
    chk("A_nacc", nacc, 3);
    chk("A_rdy_cnt", rdy_q.size(), 3);
    if (rdy_q.size() == 3) begin
      chk("A_rdy0", rdy_q[0], 0);
      chk("A_rdy1", rdy_q[1], 9);
      chk("A_rdy2", rdy_q[2], 18);
    end
    chk("A_done_rel", done_rel, 25);
    chk("A_heads", hbits, exp);
    chk("A_chain", chain_val(), exp);
    chk("A_overlap", overlap, 0);
    chk("A_idle_after", {m_s, m_b, m_r, m_d}, 4'b0001);
    prev22 = exp;

    // Verify with identical stream
    run_pass(1'b1, 3, -1, 0, -1, -1, -1);
    chk("B_err", m_e, 1'b0);
    chk("B_err_rel", err_rel, -1);
    chk("B_done_rel", done_rel, 25);

    // Verify with word 2 changed
    w[2] = 8'h3D;
    run_pass(1'b1, 3, -1, 0, -1, -1, -1);
    exp = stream_of();
    fd = first_diff(exp, prev22);
    chk("C_err", m_e, 1'b1);
    chk("C_err_rel", err_rel, fd + fd / 8 + 2);
    chk("C_chain", chain_val(), exp);
    prev22 = exp;

    // Backpressure: 5 idle cycles before word 1
    run_pass(1'b0, 3, 1, 5, -1, -1, -1);
    chk("D_nshift", nshift, 22);
    chk("D_done_rel", done_rel, 30);
    chk("D_rdy_cnt", rdy_q.size(), 8);
    chk("D_overlap", overlap, 0);
    chk("D_heads", hbits, stream_of());
    chk("D_err_cleared", m_e, 1'b0);

    // Abort while shifting word 1, then a clean reload
    for (int i = 0; i < 3; i++) w[i] = 8'($urandom);
    run_pass(1'b0, 3, -1, 0, -1, 12, -1);
    chk("E_nshift_at_abort", nshift, 11);
    run_pass(1'b0, 3, -1, 0, -1, -1, -1);
    chk("F_nshift", nshift, 22);
    chk("F_done_rel", done_rel, 25);
    chk("F_chain", chain_val(), stream_of());

    // Reset mid-shift, then a pass with a stray start while busy
    run_pass(1'b0, 3, -1, 0, -1, -1, 5);
    for (int i = 0; i < 3; i++) w[i] = 8'($urandom);
    run_pass(1'b0, 3, -1, 0, 12, -1, -1);
    chk("H_nshift", nshift, 22);
    chk("H_nacc", nacc, 3);
    chk("H_done_rel", done_rel, 25);
    chk("H_chain", chain_val(), stream_of());
    prev22 = stream_of();

    // Random verify passes with random stalls
    for (int r = 0; r < 6; r++) begin
      reuse = 1'($urandom_range(0, 1));
      if (!reuse) for (int i = 0; i < 3; i++) w[i] = 8'($urandom);
      sk = $urandom_range(0, 2);
      sn = $urandom_range(0, 4);
      run_pass(1'b1, 3, sk, sn, -1, -1, -1);
      exp = stream_of();
      chk("R_err", m_e, (exp != prev22));
      chk("R_nshift", nshift, 22);
      chk("R_done_rel", done_rel, 25 + sn);
      chk("R_heads", hbits, exp);
      chk("R_chain", chain_val(), exp);
      prev22 = exp;
    end

    // Chain equal to one word
    sel = 1'b1; L = 8;
    w[0] = 8'($urandom);
    run_pass(1'b0, 1, -1, 0, -1, -1, -1);
    chk("S_nshift", nshift, 8);
    chk("S_nacc", nacc, 1);
    chk("S_rdy_cnt", rdy_q.size(), 1);
    chk("S_done_rel", done_rel, 9);
    chk("S_heads", hbits, {24'h0, w[0]});
    chk("S_chain", chain_val(), {24'h0, w[0]});
    prev8 = stream_of();
    w[0] = w[0] ^ 8'h10;
    run_pass(1'b1, 1, -1, 0, -1, -1, -1);
    fd = first_diff(stream_of(), prev8);
    chk("S_verify_err", m_e, 1'b1);
    chk("S_err_rel", err_rel, fd + 2);
    run_pass(1'b0, 1, -1, 0, -1, -1, -1);
    chk("S_redone_rel", done_rel, 9);
    chk("S_err_after_clear", m_e, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/ccff_loader.md
# ccff_loader

Serial configuration loader for the configuration-chain flip-flop path (`ccff_head` to `ccff_tail`) of a routing or connection block tile. It accepts the bitstream as DATA_W-bit words over a valid/ready interface and serializes them LSB-first onto `ccff_head`. It drives a shift enable that gates `prog_clk` to the chain. An optional verify pass compares the bits leaving `ccff_tail` against the incoming stream and flags any mismatch.

## Interface
Parameters:
- CHAIN_LEN, 22, total configuration bits in the chain; must be at least 1.
- DATA_W, 8, width of one bitstream word; must be at least 1.
- CNT_W, $clog2(CHAIN_LEN+1), derived width of the bit counter; not overridden.

Ports:
- prog_clk  in  1  programming clock; every flop in this block is on its rising edge.
- prog_rst_n  in  1  asynchronous active-low reset.
- start  in  1  one-cycle pulse that begins a load; ignored unless the block is in IDLE or DONE.
- verify  in  1  sampled together with start; 1 enables tail comparison for the whole pass.
- abort  in  1  level input; returns the block to IDLE at the next edge.
- cfg_data  in  DATA_W  bitstream word; bit 0 is shifted first.
- cfg_valid  in  1  cfg_data is valid.
- cfg_ready  out  1  the block accepts a word at this edge.
- ccff_head  out  1  serial data into the chain; registered.
- ccff_shift_en  out  1  chain shift/clock-gate enable; registered.
- ccff_tail  in  1  serial data out of the chain.
- busy  out  1  the block is in FETCH or SHIFT.
- done  out  1  CHAIN_LEN bits have been shifted; held until the next start.
- error  out  1  sticky verify mismatch; cleared by start.

## Operation
- States:
  - IDLE: no shifting.
  - FETCH: cfg_ready=1.
  - SHIFT: ccff_shift_en=1.
  - DONE: done=1.
- IDLE or DONE, start=1:
  - Go to FETCH.
  - Clear bit counter, done and error.
  - Latch verify into verify_q.
- FETCH, cfg_valid&cfg_ready:
  - Load shift register with cfg_data.
  - Set n = min(DATA_W, CHAIN_LEN − bits_done).
  - Go to SHIFT.
- FETCH without a valid word: remain in FETCH; no timeout.
- SHIFT:
  - Each cycle, present shreg[0] on ccff_head with ccff_shift_en=1.
  - At each edge, shift shreg right and increment the bit counter.
  - After n cycles, go to FETCH if bits_done < CHAIN_LEN, otherwise go to DONE.
- Partial last word: bits n..DATA_W−1 of the last word are discarded. Exactly ceil(CHAIN_LEN/DATA_W) words are consumed per pass.
- Verify comparison:
  - Applies in every cycle where ccff_shift_en=1 and verify_q=1.
  - If ccff_tail != ccff_head, set error.
  - The host sends the same bitstream a second time, so the previous contents leave the tail in the same order they are entered.
- abort=1 in any state:
  - Next state is IDLE; ccff_shift_en=0.
  - done stays 0; error keeps its value.
  - abort has priority over start and over the handshake.
- A start pulse in FETCH or SHIFT is ignored.

## Timing
- Reset values: state IDLE, cfg_ready=0, ccff_head=0, ccff_shift_en=0, busy=0, done=0, error=0, counter=0.
- Reset asserted mid-pass: all outputs take their reset values immediately (asynchronously). Chain contents are undefined; reload is required.
- start is sampled at edge t0. cfg_ready=1 in the cycle after t0.
- Word accepted at edge t:
  - For i=0..n−1, the cycle after edge t+i carries ccff_shift_en=1 and ccff_head=data[i].
  - The chain captures bit i at edge t+i+1.
- cfg_ready is 0 throughout SHIFT, with no overlap of fetch and shift. Each word costs 1+n cycles.
- done and busy are combinational decodes of the registered state, with no glitch toward the chain.
- The cycle after the final shift cycle has ccff_shift_en=0 and done=1.
- Verify mismatch: error rises in the cycle after the edge at which the mismatching bit shifts.

## Test plan
- CHAIN_LEN=22, DATA_W=8, verify=0, cfg_valid held 1, words 0xA5, 0x3C, 0x2F, start at edge 0 -> exactly 22 shift cycles; cfg_ready high after edges 0, 9, 18; done=1 after edge 25; chain model holds 0xA5, 0x3C, then 0x2F&0x3F; 0x2F bits 6–7 never appear on ccff_head.
- Verify pass: reload the same three words with verify=1 and the chain model preloaded -> error=0, done=1; then flip word 2 to 0x3D -> error=1 one cycle after the first mismatching shift, stays 1 through DONE.
- Backpressure: cfg_valid low for 5 cycles in FETCH -> ccff_shift_en=0 and cfg_ready=1 for those cycles; shifting resumes 1 cycle after acceptance; total shift count is still 22.
- abort asserted mid-SHIFT of word 2 -> IDLE next edge, ccff_shift_en=0, done=0, busy=0; subsequent start reloads and completes normally.
- prog_rst_n pulsed low mid-SHIFT -> all outputs 0 without a clock edge; start pulsed while busy -> ignored, with no counter reset.
- CHAIN_LEN=8, DATA_W=8 -> exactly one word consumed, 8 shift cycles, done after 9 cycles; a second start from DONE clears done and error.
